// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
//
// RV32I decode stage. Takes the fetched pc/insn pair, reads the integer
// register file and registers a decode bundle (operands, immediate, class
// flags, ALU op) for the execute stage. Owns the 32x32 register file, which
// has one writeback port and an optional writeback-to-read bypass. Detects
// load-use hazards against the instruction currently held in the bundle and
// asks fetch to hold its instruction for one cycle.
//
// Handshake: fetch presents pc_in/insn while valid_in=1. The instruction is
// consumed on a rising edge unless run=0, flush=1, stall=1 or stall_req=1;
// when stall_req=1 fetch must present the same instruction again next cycle.
// valid_out qualifies the whole registered bundle; while stall=1 the bundle
// is held unchanged.
//
// Parameters
//   RF_BYPASS  1: a same-cycle writeback to rs1/rs2 is forwarded into the read
//              0: the read returns the value stored before the write
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   run, stall, flush     pipeline control (run=0 behaves like flush)
//   valid_in, pc_in, insn fetched instruction
//   wb_we, wb_rd, wb_data register file writeback port
//   stall_req             combinational load-use stall to fetch
//   valid_out, pc_out     registered bundle qualifier and PC
//   rs1, rs2, rd          register indices
//   rs1_data, rs2_data    operand values
//   imm                   sign-extended immediate
//   funct3, alu_op        insn[14:12] and ALU operation
//   is_* / illegal        instruction class flags
// -----------------------------------------------------------------------------
module instruction_decode #(
  parameter int RF_BYPASS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] insn,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall_req,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  output logic [2:0]  funct3,
  output logic [3:0]  alu_op,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        is_lui,
  output logic        is_auipc,
  output logic        is_op,
  output logic        is_opimm,
  output logic        is_system,
  output logic        illegal
);

  localparam bit BYPASS_EN = (RF_BYPASS != 0);

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd_idx;
  logic [4:0]  w_rs1_idx;
  logic [4:0]  w_rs2_idx;
  logic [2:0]  w_funct3;

  assign w_opcode  = insn[6:0];
  assign w_rd_idx  = insn[11:7];
  assign w_funct3  = insn[14:12];
  assign w_rs1_idx = insn[19:15];
  assign w_rs2_idx = insn[24:20];

  // Immediate candidates; the sign bit is always insn[31].
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_imm_i = {{20{insn[31]}}, insn[31:20]};
  assign w_imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign w_imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign w_imm_u = {insn[31:12], 12'd0};
  assign w_imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

  // ---------------------------------------------------------------------------
  // Class decode
  // ---------------------------------------------------------------------------
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_is_lui;
  logic        w_is_auipc;
  logic        w_is_op;
  logic        w_is_opimm;
  logic        w_is_system;
  logic        w_illegal;
  logic [31:0] w_imm;
  logic [3:0]  w_alu_op;

  always_comb begin
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    w_is_lui    = 1'b0;
    w_is_auipc  = 1'b0;
    w_is_op     = 1'b0;
    w_is_opimm  = 1'b0;
    w_is_system = 1'b0;
    w_illegal   = 1'b0;
    w_imm       = 32'd0;
    w_alu_op    = 4'b0000;
    case (w_opcode)
      OPC_LOAD: begin
        w_is_load = 1'b1;
        w_imm     = w_imm_i;
      end
      OPC_STORE: begin
        w_is_store = 1'b1;
        w_imm      = w_imm_s;
      end
      OPC_BRANCH: begin
        w_is_branch = 1'b1;
        w_imm       = w_imm_b;
      end
      OPC_JAL: begin
        w_is_jal = 1'b1;
        w_imm    = w_imm_j;
      end
      OPC_JALR: begin
        w_is_jalr = 1'b1;
        w_imm     = w_imm_i;
      end
      OPC_LUI: begin
        w_is_lui = 1'b1;
        w_imm    = w_imm_u;
      end
      OPC_AUIPC: begin
        w_is_auipc = 1'b1;
        w_imm      = w_imm_u;
      end
      OPC_OP: begin
        w_is_op  = 1'b1;
        w_alu_op = {insn[30], w_funct3};
      end
      OPC_OPIMM: begin
        w_is_opimm = 1'b1;
        w_imm      = w_imm_i;
        // insn[30] is part of the immediate except for the shift-right pair,
        // where it selects arithmetic vs logical shift.
        w_alu_op   = {(w_funct3 == 3'b101) ? insn[30] : 1'b0, w_funct3};
      end
      OPC_MISCMEM, OPC_SYSTEM: begin
        w_is_system = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file: x0 is hardwired to zero, reads are combinational.
  // ---------------------------------------------------------------------------
  logic [31:0] r_rf [0:31];
  logic        w_wb_write;
  logic        w_rs1_hit;
  logic        w_rs2_hit;
  logic [31:0] w_rs1_rdata;
  logic [31:0] w_rs2_rdata;

  assign w_wb_write = wb_we && (wb_rd != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= 32'd0;
      end
    end else if (w_wb_write) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  assign w_rs1_hit   = BYPASS_EN && w_wb_write && (wb_rd == w_rs1_idx);
  assign w_rs2_hit   = BYPASS_EN && w_wb_write && (wb_rd == w_rs2_idx);
  assign w_rs1_rdata = (w_rs1_idx == 5'd0) ? 32'd0 :
                       (w_rs1_hit ? wb_data : r_rf[w_rs1_idx]);
  assign w_rs2_rdata = (w_rs2_idx == 5'd0) ? 32'd0 :
                       (w_rs2_hit ? wb_data : r_rf[w_rs2_idx]);

  // ---------------------------------------------------------------------------
  // Output bundle registers
  // ---------------------------------------------------------------------------
  logic        r_valid;
  logic [31:0] r_pc;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [31:0] r_imm;
  logic [2:0]  r_funct3;
  logic [3:0]  r_alu_op;
  logic        r_is_load;
  logic        r_is_store;
  logic        r_is_branch;
  logic        r_is_jal;
  logic        r_is_jalr;
  logic        r_is_lui;
  logic        r_is_auipc;
  logic        r_is_op;
  logic        r_is_opimm;
  logic        r_is_system;
  logic        r_illegal;

  // ---------------------------------------------------------------------------
  // Load-use hazard: the bundle holds a load whose destination is read by the
  // instruction now in decode. LUI/AUIPC/JAL read no rs1; only STORE, BRANCH
  // and OP read rs2.
  // ---------------------------------------------------------------------------
  logic w_uses_rs1;
  logic w_uses_rs2;
  logic w_stall_req;

  assign w_uses_rs1  = !(w_is_lui || w_is_auipc || w_is_jal);
  assign w_uses_rs2  = w_is_store || w_is_branch || w_is_op;
  assign w_stall_req = valid_in && r_valid && r_is_load && (r_rd != 5'd0) &&
                       ((w_uses_rs1 && (r_rd == w_rs1_idx)) ||
                        (w_uses_rs2 && (r_rd == w_rs2_idx)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_pc        <= 32'd0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_rs1_data  <= 32'd0;
      r_rs2_data  <= 32'd0;
      r_imm       <= 32'd0;
      r_funct3    <= 3'd0;
      r_alu_op    <= 4'd0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_is_branch <= 1'b0;
      r_is_jal    <= 1'b0;
      r_is_jalr   <= 1'b0;
      r_is_lui    <= 1'b0;
      r_is_auipc  <= 1'b0;
      r_is_op     <= 1'b0;
      r_is_opimm  <= 1'b0;
      r_is_system <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (!run || flush) begin
      // Kill only; the remaining fields keep their last value.
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (w_stall_req) begin
        // Bubble; fetch re-presents the same instruction next cycle.
        r_valid <= 1'b0;
      end else begin
        r_valid     <= valid_in;
        r_pc        <= pc_in;
        r_rs1       <= w_rs1_idx;
        r_rs2       <= w_rs2_idx;
        r_rd        <= w_rd_idx;
        r_rs1_data  <= w_rs1_rdata;
        r_rs2_data  <= w_rs2_rdata;
        r_imm       <= w_imm;
        r_funct3    <= w_funct3;
        r_alu_op    <= w_alu_op;
        r_is_load   <= w_is_load;
        r_is_store  <= w_is_store;
        r_is_branch <= w_is_branch;
        r_is_jal    <= w_is_jal;
        r_is_jalr   <= w_is_jalr;
        r_is_lui    <= w_is_lui;
        r_is_auipc  <= w_is_auipc;
        r_is_op     <= w_is_op;
        r_is_opimm  <= w_is_opimm;
        r_is_system <= w_is_system;
        r_illegal   <= w_illegal;
      end
    end
  end

  assign stall_req = w_stall_req;
  assign valid_out = r_valid;
  assign pc_out    = r_pc;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign rd        = r_rd;
  assign rs1_data  = r_rs1_data;
  assign rs2_data  = r_rs2_data;
  assign imm       = r_imm;
  assign funct3    = r_funct3;
  assign alu_op    = r_alu_op;
  assign is_load   = r_is_load;
  assign is_store  = r_is_store;
  assign is_branch = r_is_branch;
  assign is_jal    = r_is_jal;
  assign is_jalr   = r_is_jalr;
  assign is_lui    = r_is_lui;
  assign is_auipc  = r_is_auipc;
  assign is_op     = r_is_op;
  assign is_opimm  = r_is_opimm;
  assign is_system = r_is_system;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        run, stall, flush, valid_in;
  logic [31:0] pc_in, insn;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  // DUT outputs (bypassing instance)
  logic        stall_req, valid_out;
  logic [31:0] pc_out, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic        is_op, is_opimm, is_system, illegal;

  // Non-bypassing instance outputs
  logic        n_stall_req, n_valid_out;
  logic [31:0] n_pc_out, n_rs1_data, n_rs2_data, n_imm;
  logic [4:0]  n_rs1, n_rs2, n_rd;
  logic [2:0]  n_funct3;
  logic [3:0]  n_alu_op;
  logic        n_is_load, n_is_store, n_is_branch, n_is_jal, n_is_jalr, n_is_lui;
  logic        n_is_auipc, n_is_op, n_is_opimm, n_is_system, n_illegal;

  instruction_decode #(.RF_BYPASS(1)) dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .flush(flush),
    .valid_in(valid_in), .pc_in(pc_in), .insn(insn),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_req(stall_req), .valid_out(valid_out), .pc_out(pc_out),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .funct3(funct3), .alu_op(alu_op),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_lui(is_lui), .is_auipc(is_auipc),
    .is_op(is_op), .is_opimm(is_opimm), .is_system(is_system), .illegal(illegal)
  );

  instruction_decode #(.RF_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .flush(flush),
    .valid_in(valid_in), .pc_in(pc_in), .insn(insn),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_req(n_stall_req), .valid_out(n_valid_out), .pc_out(n_pc_out),
    .rs1(n_rs1), .rs2(n_rs2), .rd(n_rd), .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
    .imm(n_imm), .funct3(n_funct3), .alu_op(n_alu_op),
    .is_load(n_is_load), .is_store(n_is_store), .is_branch(n_is_branch),
    .is_jal(n_is_jal), .is_jalr(n_is_jalr), .is_lui(n_is_lui), .is_auipc(n_is_auipc),
    .is_op(n_is_op), .is_opimm(n_is_opimm), .is_system(n_is_system), .illegal(n_illegal)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // flags: load store branch jal jalr lui auipc op opimm system illegal
  localparam logic [10:0] F_LOAD   = 11'b100_0000_0000;
  localparam logic [10:0] F_STORE  = 11'b010_0000_0000;
  localparam logic [10:0] F_BRANCH = 11'b001_0000_0000;
  localparam logic [10:0] F_JAL    = 11'b000_1000_0000;
  localparam logic [10:0] F_JALR   = 11'b000_0100_0000;
  localparam logic [10:0] F_LUI    = 11'b000_0010_0000;
  localparam logic [10:0] F_AUIPC  = 11'b000_0001_0000;
  localparam logic [10:0] F_OP     = 11'b000_0000_1000;
  localparam logic [10:0] F_OPIMM  = 11'b000_0000_0100;
  localparam logic [10:0] F_SYS    = 11'b000_0000_0010;
  localparam logic [10:0] F_ILL    = 11'b000_0000_0001;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [10:0] flags;
    logic [31:0] d1n, d2n;
  } bundle_t;

  bundle_t     dut_b;
  bundle_t     m;
  logic [31:0] m_rf [32];
  logic        last_sr;
  int          cnt_checks = 0;
  int          cnt_err = 0;

  always_comb begin
    dut_b = {valid_out, pc_out, rs1, rs2, rd, rs1_data, rs2_data, imm, funct3, alu_op,
             is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc,
             is_op, is_opimm, is_system, illegal, n_rs1_data, n_rs2_data};
  end

  function automatic logic [31:0] rf_val(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && wb_we && wb_rd == idx) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic bundle_t ref_decode(input logic [31:0] pc, input logic [31:0] i);
    bundle_t b;
    logic [2:0] f3;
    b = '0;
    f3 = i[14:12];
    b.valid = 1'b1;
    b.pc = pc;
    b.rs1 = i[19:15];
    b.rs2 = i[24:20];
    b.rd = i[11:7];
    b.f3 = f3;
    b.d1 = rf_val(i[19:15], 1'b1);
    b.d2 = rf_val(i[24:20], 1'b1);
    b.d1n = rf_val(i[19:15], 1'b0);
    b.d2n = rf_val(i[24:20], 1'b0);
    case (i[6:0])
      7'b0000011: begin b.flags = F_LOAD;   b.imm = 32'($signed(i[31:20])); end
      7'b0100011: begin b.flags = F_STORE;  b.imm = 32'($signed({i[31:25], i[11:7]})); end
      7'b1100011: begin b.flags = F_BRANCH; b.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'b1101111: begin b.flags = F_JAL;    b.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      7'b1100111: begin b.flags = F_JALR;   b.imm = 32'($signed(i[31:20])); end
      7'b0110111: begin b.flags = F_LUI;    b.imm = i & 32'hFFFF_F000; end
      7'b0010111: begin b.flags = F_AUIPC;  b.imm = i & 32'hFFFF_F000; end
      7'b0110011: begin b.flags = F_OP;     b.alu = {i[30], f3}; end
      7'b0010011: begin
        b.flags = F_OPIMM;
        b.imm = 32'($signed(i[31:20]));
        b.alu = {(f3 == 3'd5) && i[30], f3};
      end
      7'b0001111, 7'b1110011: b.flags = F_SYS;
      default: b.flags = F_ILL;
    endcase
    return b;
  endfunction

  function automatic logic ref_stall_req();
    logic [6:0] o;
    bit u1, u2;
    o = insn[6:0];
    u1 = !(o == 7'b0110111 || o == 7'b0010111 || o == 7'b1101111);
    u2 = (o == 7'b0100011 || o == 7'b1100011 || o == 7'b0110011);
    return valid_in && m.valid && (m.flags == F_LOAD) && m.rd != 0 &&
           ((u1 && m.rd == insn[19:15]) || (u2 && m.rd == insn[24:20]));
  endfunction

  task automatic model_reset();
    m = '0;
    for (int k = 0; k < 32; k++) m_rf[k] = 32'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    cnt_checks++;
    if (act !== exp) begin
      cnt_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs already driven; checks stall_req, advances the model,
  // then checks the whole registered bundle after the edge.
  task automatic step();
    bundle_t nxt;
    logic exp_sr;
    #1;
    exp_sr = ref_stall_req();
    chk("stall_req", stall_req, exp_sr);
    nxt = m;
    if (!run || flush) nxt.valid = 1'b0;
    else if (!stall) begin
      if (exp_sr) nxt.valid = 1'b0;
      else begin
        nxt = ref_decode(pc_in, insn);
        nxt.valid = valid_in;
      end
    end
    last_sr = exp_sr;
    @(posedge clk);
    m = nxt;
    if (wb_we && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
    #1;
    chk("bundle", dut_b, m);
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] i);
    valid_in = v;
    pc_in = p;
    insn = i;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    wb_we = we;
    wb_rd = r;
    wb_data = d;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] insn;
    logic [31:0] imm;
    logic [10:0] flags;
    logic [3:0]  alu;
  } vec_t;

  vec_t tbl[15];

  logic [6:0] opcs[11];

  initial begin
    tbl[0]  = '{32'hFFF28313, 32'hFFFF_FFFF, F_OPIMM,  4'b0000}; // addi x6,x5,-1
    tbl[1]  = '{32'hFE112E23, 32'hFFFF_FFFC, F_STORE,  4'b0000}; // sw
    tbl[2]  = '{32'hFE000EE3, 32'hFFFF_FFFC, F_BRANCH, 4'b0000}; // beq -4
    tbl[3]  = '{32'h0080006F, 32'h0000_0008, F_JAL,    4'b0000}; // jal +8
    tbl[4]  = '{32'h123450B7, 32'h1234_5000, F_LUI,    4'b0000}; // lui
    tbl[5]  = '{32'hFFFFF097, 32'hFFFF_F000, F_AUIPC,  4'b0000}; // auipc
    tbl[6]  = '{32'h00318233, 32'h0000_0000, F_OP,     4'b0000}; // add
    tbl[7]  = '{32'h403100B3, 32'h0000_0000, F_OP,     4'b1000}; // sub
    tbl[8]  = '{32'h40315093, 32'h0000_0403, F_OPIMM,  4'b1101}; // srai
    tbl[9]  = '{32'h40014093, 32'h0000_0400, F_OPIMM,  4'b0100}; // xori, bit30 ignored
    tbl[10] = '{32'h0000A383, 32'h0000_0000, F_LOAD,   4'b0000}; // lw x7,0(x1)
    tbl[11] = '{32'hFF8100E7, 32'hFFFF_FFF8, F_JALR,   4'b0000}; // jalr -8
    tbl[12] = '{32'h00000073, 32'h0000_0000, F_SYS,    4'b0000}; // ecall
    tbl[13] = '{32'h0FF0000F, 32'h0000_0000, F_SYS,    4'b0000}; // fence
    tbl[14] = '{32'h0000007F, 32'h0000_0000, F_ILL,    4'b0000}; // illegal
    opcs = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
             7'b0010111, 7'b0110011, 7'b0010011, 7'b0001111, 7'b1110011};

    // --- reset ---
    reset = 1'b1;
    run = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    last_sr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bundle", dut_b, 256'd0);
    chk("reset_stall_req", stall_req, 1'b0);
    reset = 1'b0;

    // --- table-driven decode ---
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), tbl[k].insn);
      step();
      chk($sformatf("tbl%0d_valid", k), valid_out, 1'b1);
      chk($sformatf("tbl%0d_imm", k), imm, tbl[k].imm);
      chk($sformatf("tbl%0d_flags", k),
          {is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc,
           is_op, is_opimm, is_system, illegal}, tbl[k].flags);
      chk($sformatf("tbl%0d_alu", k), alu_op, tbl[k].alu);
    end

    // --- write x5 then addi x6,x5,-1 ---
    drive(1'b0, 32'd0, 32'd0);
    drive_wb(1'b1, 5'd5, 32'h0000_1234);
    step();
    drive_wb(1'b0, 5'd0, 32'd0);
    drive(1'b1, 32'h8000_0000, 32'hFFF28313);
    step();
    chk("addi_valid", valid_out, 1'b1);
    chk("addi_rs1_data", rs1_data, 32'h1234);
    chk("addi_imm", imm, 32'hFFFF_FFFF);
    chk("addi_opimm", is_opimm, 1'b1);
    chk("addi_alu", alu_op, 4'b0000);
    chk("addi_rd", rd, 5'd6);
    chk("addi_pc", pc_out, 32'h8000_0000);

    // --- load-use hazard: one bubble ---
    drive(1'b1, 32'h200, 32'h0000A383);          // lw x7,0(x1)
    step();
    drive(1'b1, 32'h204, 32'h00238433);          // add x8,x7,x2
    #1;
    chk("lu_stall_req_hi", stall_req, 1'b1);
    step();
    chk("lu_bubble", valid_out, 1'b0);
    chk("lu_stall_req_lo", stall_req, 1'b0);
    step();
    chk("lu_add_valid", valid_out, 1'b1);
    chk("lu_add_op", is_op, 1'b1);
    chk("lu_add_pc", pc_out, 32'h204);
    drive(1'b1, 32'h208, 32'h0000A003);          // lw x0,0(x1)
    step();
    drive(1'b1, 32'h20C, 32'h00200433);          // add x8,x0,x2
    #1;
    chk("lu_x0_no_stall", stall_req, 1'b0);
    step();
    chk("lu_x0_valid", valid_out, 1'b1);

    // --- writeback bypass ---
    drive(1'b1, 32'h300, 32'h00318233);          // add x4,x3,x3
    drive_wb(1'b1, 5'd3, 32'hDEAD_BEEF);
    step();
    chk("byp_rs1", rs1_data, 32'hDEAD_BEEF);
    chk("byp_rs2", rs2_data, 32'hDEAD_BEEF);
    chk("nobyp_rs1", n_rs1_data, 32'd0);
    chk("nobyp_rs2", n_rs2_data, 32'd0);
    drive(1'b1, 32'h304, 32'h00000233);          // add x4,x0,x0
    drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    chk("x0_byp_rs1", rs1_data, 32'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    step();
    chk("x0_read_rs1", rs1_data, 32'd0);

    // --- stall held 3 cycles ---
    drive(1'b1, 32'h400, 32'h403100B3);          // sub
    step();
    stall = 1'b1;
    drive(1'b1, 32'h404, 32'h123450B7);          // lui presented while stalled
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", pc_out, 32'h400);
      chk("stall_alu", alu_op, 4'b1000);
      chk("stall_valid", valid_out, 1'b1);
    end
    flush = 1'b1;
    step();
    chk("flush_stall", valid_out, 1'b0);
    stall = 1'b0;
    flush = 1'b0;

    // --- flush beats stall_req ---
    drive(1'b1, 32'h500, 32'h0000A383);          // lw x7
    step();
    drive(1'b1, 32'h504, 32'h00238433);          // add x8,x7,x2
    flush = 1'b1;
    step();
    chk("flush_sr", valid_out, 1'b0);
    flush = 1'b0;

    // --- run=0 ---
    run = 1'b0;
    drive(1'b1, 32'h600, 32'h00318233);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("run0_valid", valid_out, 1'b0);
    end
    run = 1'b1;
    step();
    chk("run1_valid", valid_out, 1'b1);

    // --- asynchronous reset mid-operation ---
    reset = 1'b1;
    #1;
    chk("async_rst_valid", valid_out, 1'b0);
    chk("async_rst_pc", pc_out, 32'd0);
    model_reset();
    last_sr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // --- randomized traffic against the model ---
    for (int n = 0; n < 3000; n++) begin
      run = ($urandom_range(0, 99) < 95);
      flush = ($urandom_range(0, 99) < 6);
      stall = ($urandom_range(0, 99) < 15);
      if (!last_sr) begin
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 11) == 0) r[6:0] = 7'($urandom);
        else r[6:0] = opcs[$urandom_range(0, 10)];
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        drive(($urandom_range(0, 9) < 8), $urandom & 32'hFFFF_FFFC, r);
      end
      drive_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 8)), $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", cnt_checks, cnt_err);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

RV32I decode stage sitting directly downstream of instruction fetch. It consumes the fetched `pc`/`insn` pair and produces a registered decode bundle for execute: register operands, immediate, control class flags and ALU op. It owns the 32x32 integer register file, with one writeback port and optional write-to-read bypass. It also detects load-use hazards and raises a stall request back to fetch.

## Interface
- `RF_BYPASS`, default 1: 1 = a same-cycle writeback to rs1/rs2 is forwarded into the operand read; 0 = register file returns the old value.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `run` in 1: 0 = treat every cycle as flush.
- `stall` in 1: downstream stall; hold the output bundle.
- `flush` in 1: branch/jump redirect; kill the instruction in decode.
- `valid_in` in 1: fetch `run_out`; `pc_in`/`insn` valid this cycle.
- `pc_in` in 32: PC of `insn`.
- `insn` in 32: instruction word.
- `wb_we` in 1: register file write enable.
- `wb_rd` in 5: writeback index.
- `wb_data` in 32: writeback data.
- `stall_req` out 1: combinational load-use stall to fetch.
- `valid_out` out 1: bundle valid.
- `pc_out` out 32: registered PC.
- `rs1`, `rs2`, `rd` out 5 each: register indices.
- `rs1_data`, `rs2_data` out 32: operand values.
- `imm` out 32: sign-extended immediate.
- `funct3` out 3: insn[14:12].
- `alu_op` out 4: ALU operation.
- `is_load`, `is_store`, `is_branch`, `is_jal`, `is_jalr`, `is_lui`, `is_auipc`, `is_op`, `is_opimm`, `is_system`, `illegal` out 1 each: class flags.

## Operation
- Opcode classes: LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, OP 0110011, OP-IMM 0010011, and `is_system` for MISC-MEM 0001111 or SYSTEM 1110011 (both executed as no-ops). Any other opcode sets `illegal`=1 with all other flags 0; `valid_out` is still 1.
- Immediate by class:
  - I-type: LOAD, JALR, OP-IMM.
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - U-type: LUI, AUIPC, low 12 bits 0.
  - J-type: JAL, bit0=0.
  - All others: 0.
  - Sign bit is always insn[31].
- `alu_op`:
  - OP: {insn[30], funct3}.
  - OP-IMM: {funct3==3'b101 ? insn[30] : 0, funct3}.
  - All other classes: 4'b0000.
- Register file:
  - x0 reads 0; writes with `wb_rd`=0 are ignored.
  - Writes land on the rising edge when `wb_we`=1.
  - Reads are combinational from the current `insn`, then registered into `rs1_data`/`rs2_data`.
  - With `RF_BYPASS`=1, if `wb_we`, `wb_rd`!=0 and `wb_rd`==rs, the read value is `wb_data`.
- Load-use hazard: `stall_req` = `valid_in` & `valid_out` & `is_load` & (`rd`!=0) & (`rd`==insn rs1 | (`rd`==insn rs2 & insn uses rs2)). STORE, BRANCH and OP use rs2; only LUI, AUIPC and JAL use no rs1.
- Update priority per rising edge:
  1. `reset`, `run`=0 or `flush`: `valid_out`<=0; other bundle fields don't-care but held.
  2. `stall`: hold the entire bundle.
  3. `stall_req`: insert a bubble (`valid_out`<=0); the input is not consumed, and fetch holds it.
  4. Otherwise: capture the decode of the inputs; `valid_out`<=`valid_in`.
- Register file writes proceed regardless of `stall`, `flush` or `stall_req`.

## Timing
- Latency: 1 cycle, from input present to bundle registered.
- Reset values: every output register is 0, including `pc_out`=0 and all flags. All 32 register file entries are 0. `stall_req` is 0 because `valid_out`=0.
- Reset mid-operation clears `valid_out` asynchronously.
- A load-use hazard costs exactly one bubble. The next cycle `valid_out`=0, so `stall_req` drops and the held instruction is decoded.
- `flush` in the same cycle as `stall` or `stall_req`: flush wins, `valid_out`<=0.
- Writeback in the same cycle as decode of a reader: bypassed value when `RF_BYPASS`=1, old value when 0.

## Test plan
- After reset, write x5=0x0000_1234 via wb. Then present `addi x6,x5,-1` (0xFFF28313) with pc 0x8000_0000 -> next cycle `valid_out`=1, `rs1_data`=0x1234, `imm`=0xFFFF_FFFF, `is_opimm`=1, `alu_op`=0000, `rd`=6.
- `lw x7,0(x1)` followed by `add x8,x7,x2` -> `stall_req`=1 for one cycle, one bubble (`valid_out`=0), then the add issues with `is_op`=1. A subsequent `add x8,x0,x2` after a load to x0 -> no stall.
- Immediate formats:
  - `sw` 0xFE112E23 -> `imm`=0xFFFF_FFFC.
  - `beq` with imm -4 -> `imm`=0xFFFF_FFFC.
  - `jal` 0x0080006F -> `imm`=8.
  - `lui x1,0x12345` -> `imm`=0x1234_5000.
- `wb_we`=1, `wb_rd`=3, `wb_data`=0xDEAD_BEEF in the same cycle as decoding `add x4,x3,x3` -> both operands 0xDEADBEEF when `RF_BYPASS`=1, 0 when `RF_BYPASS`=0. A write to x0 -> x0 still reads 0.
- Control interactions:
  - `stall` held 3 cycles -> bundle unchanged.
  - `flush` with `stall` -> `valid_out`=0 next cycle.
  - `run`=0 -> `valid_out` stays 0.
  - Opcode 0x0000007F -> `illegal`=1, `valid_out`=1.
